// File: rtl/caldet_pkg.sv
// ============================================================================
// Module   : caldet_pkg
// Brief    : Shared types and elaboration helpers for the caldet sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package caldet_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_CALC = 2'd2,
        ST_DONE = 2'd3
    } state_e;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) r++;
        end
        return r;
    endfunction

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int cnt_w(input int limit);
        return (clog2(limit + 1) < 1) ? 1 : clog2(limit + 1);
    endfunction

    function automatic int calc_beats(input int elems, input int ports);
        return (elems + ports - 1) / ports;
    endfunction

endpackage

`default_nettype wire

// File: rtl/caldet_addr_gen.sv
// ============================================================================
// Module   : caldet_addr_gen
// Brief    : Combinational read-address and lane-valid generation per beat.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module caldet_addr_gen #(
    parameter int ELEMS  = 4,
    parameter int PORTS  = 4,
    parameter int N_MAT  = 2,
    parameter int ADDR_W = 4,
    parameter int BASE   = 0,
    parameter int BW     = 1
) (
    input  logic [BW-1:0]               beat_i,
    input  logic [N_MAT-1:0]            sel_i,
    input  logic                        read_i,
    output logic [N_MAT*PORTS*ADDR_W-1:0] ra_o,
    output logic [N_MAT-1:0]            ra_valid_o,
    output logic [PORTS-1:0]            lane_valid_o
);

    logic [PORTS*ADDR_W-1:0] lane_addr;

    for (genvar gp = 0; gp < PORTS; gp++) begin : g_lane
        logic [31:0] idx;
        logic        live;
        assign idx  = 32'(beat_i) * 32'(PORTS) + 32'(gp);
        assign live = read_i && (idx < 32'(ELEMS));
        assign lane_addr[gp*ADDR_W +: ADDR_W] = live ? ADDR_W'(32'(BASE) + idx) : '0;
        assign lane_valid_o[gp] = live;
    end

    // Every selected matrix sees the same lane addresses; deselected ones stay at zero.
    for (genvar gm = 0; gm < N_MAT; gm++) begin : g_mat
        assign ra_o[gm*PORTS*ADDR_W +: PORTS*ADDR_W] =
            (read_i && sel_i[gm]) ? lane_addr : '0;
    end

    assign ra_valid_o = read_i ? sel_i : '0;

endmodule

`default_nettype wire

// File: rtl/control_caldet_seq.sv
// ============================================================================
// Module   : control_caldet_seq
// Brief    : Determinant-read sequencer: READ beats, CALC latency, DONE pulse.
//            Optional CALDET_BACK2BACK_EN accepts a new start during DONE.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module control_caldet_seq
    import caldet_pkg::*;
#(
    parameter int ELEMS    = 4,
    parameter int PORTS    = 4,
    parameter int N_MAT    = 2,
    parameter int ADDR_W   = 4,
    parameter int BASE     = 0,
    parameter int CALC_LAT = 2
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          start,
    input  logic                          abort,
    input  logic [N_MAT-1:0]              mat_sel,
    output logic [N_MAT*PORTS*ADDR_W-1:0] ra,
    output logic [N_MAT-1:0]              ra_valid,
    output logic [PORTS-1:0]              lane_valid,
    output logic                          encaldet,
    output logic                          donecaldet,
    output logic                          busy
);

    localparam int BEATS = calc_beats(ELEMS, PORTS);
    localparam int BW    = cnt_w(BEATS);
    localparam int LW    = cnt_w(CALC_LAT);

    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'((CALC_LAT > 0) ? CALC_LAT - 1 : 0);

    state_e             state_q, state_d;
    logic [BW-1:0]      beat_q, beat_d;
    logic [LW-1:0]      lat_q, lat_d;
    logic [N_MAT-1:0]   sel_q, sel_d;
    logic               en_q, done_q, busy_q;
    logic               accept;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        sel_d   = sel_q;
        accept  = 1'b0;

        case (state_q)
            ST_IDLE: accept = start && !abort;
            ST_READ: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (beat_q == BEAT_LAST) begin
                    state_d = (CALC_LAT == 0) ? ST_DONE : ST_CALC;
                    lat_d   = '0;
                end else begin
                    beat_d = beat_q + BW'(1);
                end
            end
            ST_CALC: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (lat_q == LAT_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
`ifdef CALDET_BACK2BACK_EN
                accept = start && !abort;
`endif
            end
            default: state_d = ST_IDLE;
        endcase

        if (accept) begin
            state_d = ST_READ;
            sel_d   = mat_sel;
            beat_d  = '0;
        end
        if (state_d == ST_IDLE) begin
            sel_d  = '0;
            beat_d = '0;
            lat_d  = '0;
        end
    end

    // Status outputs are decoded from the next state so they leave a flop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            beat_q  <= '0;
            lat_q   <= '0;
            sel_q   <= '0;
            en_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            lat_q   <= lat_d;
            sel_q   <= sel_d;
            en_q    <= (state_d == ST_READ) || (state_d == ST_CALC);
            done_q  <= (state_d == ST_DONE);
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    caldet_addr_gen #(
        .ELEMS  (ELEMS),
        .PORTS  (PORTS),
        .N_MAT  (N_MAT),
        .ADDR_W (ADDR_W),
        .BASE   (BASE),
        .BW     (BW)
    ) u_addr_gen (
        .beat_i       (beat_q),
        .sel_i        (sel_q),
        .read_i       (state_q == ST_READ),
        .ra_o         (ra),
        .ra_valid_o   (ra_valid),
        .lane_valid_o (lane_valid)
    );

    assign encaldet   = en_q;
    assign donecaldet = done_q;
    assign busy       = busy_q;

endmodule

`default_nettype wire
